// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: constants shared by the UART ALU datapath stages.
package uart_alu_pkg;
    localparam logic [1:0] WAIT_A  = 2'd0;
    localparam logic [1:0] WAIT_B  = 2'd1;
    localparam logic [1:0] WAIT_OP = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;
    localparam int DEFAULT_TIMEOUT_TICKS = 1600;
    localparam int OP_BITS = 6;
    localparam logic [7:0] STATUS_OK = 8'h55;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles {A, B, OP} frames from UART bytes with inter-byte
// timeout and opcode check, and hands commands out over valid/ready.
module uart_cmd_parser
    import uart_alu_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int OP_BITS       = uart_alu_pkg::OP_BITS,
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    parameter int CNT_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic                 rx_done_tick,
    input  logic [7:0]           rx_data,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [DATA_BITS-1:0] cmd_a,
    output logic [DATA_BITS-1:0] cmd_b,
    output logic [OP_BITS-1:0]   cmd_op,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_opcode,
    output logic                 err_overrun,
    output logic [CNT_BITS-1:0]  frame_cnt,
    output logic [CNT_BITS-1:0]  err_cnt
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [1:0]           r_state, w_state_nxt;
    logic [TW-1:0]        r_tcnt;
    logic [DATA_BITS-1:0] r_a, r_b;
    logic [OP_BITS-1:0]   r_op;
    logic                 r_err_to, r_err_op, r_err_ov;
    logic                 w_op_ok, w_xfer, w_expire, w_ev_to, w_ev_op, w_ev_ov;
    assign w_op_ok = (rx_data >> OP_BITS) == 8'd0;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= WAIT_A;
        else r_state <= w_state_nxt;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_A:  w_state_nxt = rx_done_tick ? WAIT_B : WAIT_A;
            WAIT_B:  w_state_nxt = rx_done_tick ? WAIT_OP : w_expire ? WAIT_A : WAIT_B;
            WAIT_OP: w_state_nxt = rx_done_tick ? (w_op_ok ? HOLD : WAIT_A) : w_expire ? WAIT_A : WAIT_OP;
            default: w_state_nxt = cmd_ready ? (rx_done_tick ? WAIT_B : WAIT_A) : HOLD;
        endcase
    end
    always_comb begin
        cmd_valid = r_state == HOLD;
        busy      = (r_state == WAIT_B) || (r_state == WAIT_OP);
        w_xfer    = cmd_valid && cmd_ready;
        w_expire  = busy && s_tick && (r_tcnt == TW'(TIMEOUT_TICKS - 1));
        w_ev_to   = w_expire && !rx_done_tick;
        w_ev_op   = (r_state == WAIT_OP) && rx_done_tick && !w_op_ok;
        w_ev_ov   = cmd_valid && rx_done_tick && !cmd_ready;
    end
    // A byte arriving on the expiry cycle wins and restarts the count.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_tcnt <= '0;
        else r_tcnt <= (!busy || rx_done_tick || w_expire) ? '0 : r_tcnt + TW'(s_tick);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_err_to <= 1'b0;
            r_err_op <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            if (rx_done_tick && ((r_state == WAIT_A) || w_xfer)) r_a <= DATA_BITS'(rx_data);
            if (rx_done_tick && (r_state == WAIT_B)) r_b <= DATA_BITS'(rx_data);
            if (rx_done_tick && (r_state == WAIT_OP) && w_op_ok) r_op <= OP_BITS'(rx_data);
            r_err_to <= w_ev_to;
            r_err_op <= w_ev_op;
            r_err_ov <= w_ev_ov;
        end
    assign cmd_a       = r_a;
    assign cmd_b       = r_b;
    assign cmd_op      = r_op;
    assign err_timeout = r_err_to;
    assign err_opcode  = r_err_op;
    assign err_overrun = r_err_ov;
    sat_counter #(.W(CNT_BITS)) u_frame_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .i_inc  (w_xfer),
        .o_cnt  (frame_cnt)
    );
    sat_counter #(.W(CNT_BITS)) u_err_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .i_inc  (w_ev_to || w_ev_op || w_ev_ov),
        .o_cnt  (err_cnt)
    );
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed scenarios plus random traffic, checked every
// cycle against a byte-count/queue level model of the command parser.
module tb_uart_cmd_parser;
    localparam int TO = 1600;
    logic       clk = 0, reset_n = 0, s_tick = 0, rx_done_tick = 0, cmd_ready = 0;
    logic [7:0] rx_data = 0;
    logic       cmd_valid, busy, err_timeout, err_opcode, err_overrun;
    logic [7:0] cmd_a, cmd_b, frame_cnt, err_cnt;
    logic [5:0] cmd_op;
    int n_cmp = 0, n_bad = 0;
    int tick_mode = 0, rdy_mode = 0;
    int m_n = 0, m_a = 0, m_b = 0, m_op = 0, m_ticks = 0, m_fc = 0, m_ec = 0;
    bit m_hold = 0, m_to = 0, m_oe = 0, m_ov = 0;
    int n_val = 0, n_to = 0, n_oe = 0, n_ov = 0, v_a = -1, v_b = -1, v_op = -1;
    int s_val, s_to, s_oe, s_ov;

    uart_cmd_parser dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_done_tick(rx_done_tick),
        .rx_data(rx_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .busy(busy),
        .err_timeout(err_timeout), .err_opcode(err_opcode), .err_overrun(err_overrun),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a count of collected bytes; errors and handshakes follow the frame rules.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_n = 0; m_a = 0; m_b = 0; m_op = 0; m_ticks = 0; m_fc = 0; m_ec = 0;
            m_hold = 0; m_to = 0; m_oe = 0; m_ov = 0;
        end else begin
            m_to = 0; m_oe = 0; m_ov = 0;
            if (m_hold) begin
                if (cmd_ready) begin
                    m_fc = (m_fc < 255) ? m_fc + 1 : 255;
                    m_hold = 0;
                    if (rx_done_tick) begin m_a = rx_data; m_n = 1; end
                end else if (rx_done_tick) m_ov = 1;
            end else if (rx_done_tick) begin
                if (m_n == 0) begin m_a = rx_data; m_n = 1; end
                else if (m_n == 1) begin m_b = rx_data; m_n = 2; end
                else begin
                    m_n = 0;
                    if (rx_data < 64) begin m_op = rx_data; m_hold = 1; end
                    else m_oe = 1;
                end
            end else if (m_n > 0 && s_tick) begin
                m_ticks++;
                if (m_ticks == TO) begin m_to = 1; m_n = 0; end
            end
            if (rx_done_tick || m_n == 0) m_ticks = 0;
            if (m_to || m_oe || m_ov) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
        end
        #1;
        chk("cmd_valid", cmd_valid, m_hold);
        chk("busy", busy, m_n > 0);
        chk("cmd_a", cmd_a, m_a);
        chk("cmd_b", cmd_b, m_b);
        chk("cmd_op", cmd_op, m_op);
        chk("err_timeout", err_timeout, m_to);
        chk("err_opcode", err_opcode, m_oe);
        chk("err_overrun", err_overrun, m_ov);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("err_cnt", err_cnt, m_ec);
        if (cmd_valid) begin n_val++; v_a = cmd_a; v_b = cmd_b; v_op = cmd_op; end
        if (err_timeout) n_to++;
        if (err_opcode) n_oe++;
        if (err_overrun) n_ov++;
    end

    task automatic step(input bit rx, input logic [7:0] d);
        @(negedge clk);
        rx_done_tick = rx;
        rx_data = d;
        s_tick = (tick_mode == 1) ? 1'b1 : (tick_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        cmd_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b);
        step(0, 8'($urandom));
    endtask

    task automatic snap();
        s_val = n_val; s_to = n_to; s_oe = n_oe; s_ov = n_ov;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_a"}, cmd_a, 0);
        chk({tag, "_b"}, cmd_b, 0);
        chk({tag, "_fcnt"}, frame_cnt, 0);
        chk({tag, "_ecnt"}, err_cnt, 0);
    endtask

    initial begin
        idle(3);
        @(negedge clk) reset_n = 1;
        idle(2);
        chk_zero("reset");
        // basic frame, consumer always ready
        rdy_mode = 1; snap();
        send(8'h12); send(8'h34); send(8'h20); idle(3);
        chk("t1_valid_cycles", n_val - s_val, 1);
        chk("t1_a", v_a, 'h12); chk("t1_b", v_b, 'h34); chk("t1_op", v_op, 'h20);
        chk("t1_fcnt", frame_cnt, 1); chk("t1_ecnt", err_cnt, 0);
        // held command with an overrun byte
        rdy_mode = 0; snap();
        send(8'h05); send(8'h03); send(8'h22); idle(20); send(8'hAA); idle(29);
        chk("t2_valid", cmd_valid, 1); chk("t2_a", cmd_a, 'h05);
        chk("t2_ovr", n_ov - s_ov, 1); chk("t2_ecnt", err_cnt, 1);
        rdy_mode = 1; idle(2);
        chk("t2_fcnt", frame_cnt, 2); chk("t2_xfer_a", v_a, 'h05);
        // stalled partial frame
        tick_mode = 1; snap();
        send(8'h07); idle(1605);
        chk("t3_timeout", n_to - s_to, 1); chk("t3_busy", busy, 0);
        send(8'h01); send(8'h02); send(8'h20); idle(3);
        chk("t3_a", v_a, 'h01); chk("t3_fcnt", frame_cnt, 3); chk("t3_ecnt", err_cnt, 2);
        // illegal opcode
        tick_mode = 0; snap();
        send(8'h11); send(8'h22); send(8'hE0); idle(3);
        chk("t4_operr", n_oe - s_oe, 1); chk("t4_novalid", n_val - s_val, 0); chk("t4_busy", busy, 0);
        send(8'h33); send(8'h44); send(8'h3F); idle(3);
        chk("t4_a", v_a, 'h33); chk("t4_op", v_op, 'h3F); chk("t4_fcnt", frame_cnt, 4);
        // byte on the expiry tick
        tick_mode = 1; snap();
        step(1, 8'h09); idle(1599); send(8'h0A);
        tick_mode = 0;
        chk("t5_no_timeout", n_to - s_to, 0); chk("t5_busy", busy, 1); chk("t5_b", cmd_b, 'h0A);
        send(8'h01); idle(3);
        chk("t5_fcnt", frame_cnt, 5);
        // asynchronous reset in WAIT_OP and in HOLD
        rdy_mode = 0;
        send(8'h01); send(8'h02);
        #3 reset_n = 0;
        #1 chk_zero("rst_waitop");
        @(negedge clk) reset_n = 1;
        send(8'h05); send(8'h06); send(8'h07); idle(2);
        chk("hold_valid", cmd_valid, 1);
        #3 reset_n = 0;
        #1 chk_zero("rst_hold");
        @(negedge clk) reset_n = 1;
        // error counter saturation
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin send(8'h01); send(8'h02); send(8'hFF); end
        idle(2);
        chk("sat_ecnt", err_cnt, 255); chk("sat_fcnt", frame_cnt, 0);
        // random traffic
        tick_mode = 2; rdy_mode = 2;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63)));
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
